// File: rtl/db9md_pad_scanner.sv
// Two-player Mega Drive 3/6-button pad scanner over a shared DB9 port.
// Walks the pad select sequence per player and commits decoded words atomically.
module db9md_pad_scanner #(
  parameter int unsigned PHASE_CYCLES  = 48,
  parameter int unsigned SETTLE_CYCLES = 96,
  parameter int unsigned POLL_CYCLES   = 36000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        scan_done
);

  localparam int unsigned CNT_A   = (PHASE_CYCLES > SETTLE_CYCLES) ? PHASE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX = (CNT_A > POLL_CYCLES) ? CNT_A : POLL_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_PHASE,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    phase_q, phase_d;
  logic          split_d;
  logic [5:0]    sync1_q, sync2_q;
  logic [11:0]   shadow_q;
  logic          conn_q, six_q;
  logic          sample;
  logic [15:0]   word;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    split_d = joy_split;
    case (state_q)
      S_IDLE: begin
        if (cnt_q == CW'(POLL_CYCLES - 1)) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          split_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = S_PHASE;
          cnt_d   = '0;
          phase_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PHASE: begin
        if (cnt_q == CW'(PHASE_CYCLES - 1)) begin
          cnt_d = '0;
          if (phase_q == 3'd7) state_d = S_COMMIT;
          else                 phase_d = phase_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_COMMIT: begin
        cnt_d = '0;
        if (!joy_split) begin
          split_d = 1'b1;
          state_d = S_SETTLE;
        end else begin
          split_d = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        split_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        phase_d = '0;
        split_d = 1'b0;
      end
    endcase
  end

  assign sample = (state_q == S_PHASE) && (cnt_q == CW'(PHASE_CYCLES - 1));
  // Extended buttons only count when the pad identified itself as 6-button.
  assign word = conn_q ? {4'h0, (six_q ? shadow_q[11:8] : 4'h0), shadow_q[7:0]} : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      joy_mdsel <= 1'b1;
      joy_split <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      joy_mdsel <= (state_d == S_PHASE) ? ~phase_d[0] : 1'b1;
      joy_split <= split_d;
      scan_done <= (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      shadow_q  <= '0;
      conn_q    <= 1'b0;
      six_q     <= 1'b0;
      joystick1 <= '0;
      joystick2 <= '0;
    end else begin
      sync1_q <= joy_in;
      sync2_q <= sync1_q;
      if (state_q == S_COMMIT) begin
        if (!joy_split) joystick1 <= word;
        else            joystick2 <= word;
      end
      if (state_d == S_SETTLE && state_q != S_SETTLE) begin
        shadow_q <= '0;
        conn_q   <= 1'b0;
        six_q    <= 1'b0;
      end else if (sample) begin
        case (phase_q)
          3'd0: shadow_q[5:0] <= {~sync2_q[5], ~sync2_q[4], ~sync2_q[0], ~sync2_q[1],
                                  ~sync2_q[2], ~sync2_q[3]};
          3'd1: begin
            shadow_q[7:6] <= ~sync2_q[5:4];
            conn_q        <= (sync2_q[3:2] == 2'b00);
          end
          3'd5: six_q <= (sync2_q[3:0] == 4'b0000);
          3'd6: if (six_q) shadow_q[11:8] <= {~sync2_q[0], ~sync2_q[1], ~sync2_q[2], ~sync2_q[3]};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/db9md_pad_scanner.md
Name: db9md_pad_scanner

Overview:
- Scans two Sega Mega Drive 3/6-button pads that share one 6-wire DB9 input through the SNAC user port.
- Drives the pad select line (joy_mdsel) and the player multiplexer line (joy_split).
- Decodes the active-low pad pins into active-high 16-bit joystick words.
- Sits directly upstream of the top-level joystick remap that feeds the game core's CTR1/CTR2 inputs.

Parameters:
- PHASE_CYCLES, 48, clocks each select phase is held; must be ≥ 4. Sampling happens on the last cycle of the phase.
- SETTLE_CYCLES, 96, clocks joy_split is held with mdsel high before the first phase of a player.
- POLL_CYCLES, 36000, idle clocks between the end of one full scan and the start of the next (1.5 ms at 24 MHz, long enough for the pad's internal counter to reset).

Ports:
- clk, input, 1: system clock (24 MHz).
- reset_n, input, 1: asynchronous active-low reset.
- joy_in, input, 6: pad pins, active low. Meaning per bit depends on select:
  - mdsel=1: [0]Up [1]Down [2]Left [3]Right [4]B [5]C.
  - mdsel=0: [4]A [5]Start, with [3:0] used for detection.
  - 6-button phase 6: [0]Z [1]Y [2]X [3]Mode.
- joy_mdsel, output, 1: pad select line.
- joy_split, output, 1: 0 selects player 1, 1 selects player 2.
- joystick1, output, 16: active-high buttons for player 1. [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Mode [9]X [10]Y [11]Z; [15:12] always 0.
- joystick2, output, 16: same layout for player 2.
- scan_done, output, 1: one-clock pulse after both players have been committed.

Behaviour:
- Reset values: joy_mdsel=1, joy_split=0, joystick1=joystick2=16'h0000, scan_done=0. The FSM enters IDLE with its counter at 0. Reset mid-scan aborts the scan immediately; the shadow registers are discarded.
- Input synchroniser: joy_in passes through a 2-FF synchroniser, so sampled data is 2 clocks old.
- FSM states: IDLE → SETTLE → PHASE → COMMIT, then either back to SETTLE for player 2 or to DONE → IDLE.
- IDLE: joy_mdsel=1. Counts POLL_CYCLES clocks, then sets joy_split=0 and goes to SETTLE.
- SETTLE: holds for SETTLE_CYCLES clocks with joy_mdsel=1, then goes to PHASE with phase index p=0.
- PHASE: p runs 0..7, each lasting PHASE_CYCLES clocks, with joy_mdsel = ~p[0] (p0 high, p1 low, …). On the last cycle of each phase the synchronised inputs are inverted and sampled into a shadow register:
  - p0: U, D, L, R, B, C.
  - p1: A, Start. connected flag = (raw Left==0 && raw Right==0).
  - p5: six flag = (raw [3:0]==4'b0000).
  - p6: if six, Z, Y, X, Mode.
  - After p7, go to COMMIT.
- COMMIT (1 clock): writes the shadow register to joystick1 if joy_split=0, or to joystick2 if joy_split=1. All 16 bits update in the same clock.
  - If connected=0, the word is 16'h0000.
  - If connected=1 and six=0, bits [11:8] are 0.
  - If joy_split=0: set joy_split=1, clear the shadow, go to SETTLE.
  - Else: go to DONE.
- DONE (1 clock): scan_done=1, joy_mdsel=1, joy_split=0, go to IDLE with counter cleared.
- Outputs are registered. Between commits joystick1/2 hold their last committed value (no partial updates are visible).
- Scan length per player = SETTLE_CYCLES + 8·PHASE_CYCLES + 1 clocks. The full period is 2·that + 1 + POLL_CYCLES.
- All counters saturate or reload at their terminal value; none wraps into an undefined state. Unused FSM encodings go to IDLE.

Test Plan:
- Reset → joystick1/2 = 0000, mdsel=1, split=0. Assert reset_n low mid-PHASE → outputs return to reset values within 1 clock (async), and the scan restarts from IDLE.
- No pad (joy_in=6'h3F constant) → after scan_done, joystick1 = joystick2 = 0000.
- 3-button model on player 1 holding Up+A: model drives [3:0]=0 when mdsel=0 and never reports all-low at p5 → joystick1=16'h0048, [11:8]=0.
- 6-button model on player 2 holding C+Start+Z+Mode → joystick2=16'h09A0, while joystick1 holds its previous value.
- Timing check with PHASE_CYCLES=4, SETTLE_CYCLES=8, POLL_CYCLES=16:
  - joy_mdsel toggles every 4 clocks, starting high.
  - scan_done occurs at clock 16+2·(8+32+1)+1 after reset.
  - joy_split rises exactly one clock after the first commit.
- Pad button changes mid-scan (after p0) → the change is not visible until the next scan, and both words update atomically on their COMMIT clocks only.
